// File: rtl/sram_bus_slave.sv
// Memory-bus slave that bridges accesses within its address window to an external async SRAM.
// Optional macro SRAM_TURNAROUND_EN inserts a bus turnaround cycle between a read and a following write.
module sram_bus_slave #(
   parameter logic [31:0] BASE_ADDR = 32'h0,
   parameter int          WIN_BITS  = 15,
   parameter int          SRAM_AW   = 13,
   parameter int          RD_WAIT   = 2,
   parameter int          WR_WAIT   = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               rreq,
   input  logic               wreq,
   input  logic [31:0]        addr,
   input  logic [31:0]        wdata,
   output logic [31:0]        rdata,
   output logic               ack,
   output logic               busy,
   output logic [SRAM_AW-1:0] sram_addr,
   output logic [31:0]        sram_dq_o,
   input  logic [31:0]        sram_dq_i,
   output logic               sram_dq_oe,
   output logic               sram_ce_n,
   output logic               sram_oe_n,
   output logic               sram_we_n
);

   localparam int MAX_WAIT = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
   localparam int CW       = $clog2(MAX_WAIT + 1);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_RD       = 3'd1,
      ST_WR_SETUP = 3'd2,
      ST_WR_PULSE = 3'd3,
      ST_WR_HOLD  = 3'd4,
`ifdef SRAM_TURNAROUND_EN
      ST_DONE     = 3'd5,
      ST_TURN     = 3'd6
`else
      ST_DONE     = 3'd5
`endif
   } state_t;

   state_t        state_r;
   state_t        state_nxt_s;
   logic [CW-1:0] cnt_r;
   logic [CW-1:0] cnt_nxt_s;
   logic          hit_s;
   logic          acc_wr_s;
   logic          acc_rd_s;
   logic          rd_last_s;
   logic          addr_unused_s;
`ifdef SRAM_TURNAROUND_EN
   logic          last_rd_r;
`endif

   // Pin levels for a state, packed as {busy, ce_n, oe_n, we_n, dq_oe}.
   function automatic logic [4:0] strobes(input state_t st);
      case (st)
         ST_IDLE:     strobes = 5'b0_1_1_1_0;
         ST_RD:       strobes = 5'b1_0_0_1_0;
         ST_WR_SETUP: strobes = 5'b1_0_1_1_1;
         ST_WR_PULSE: strobes = 5'b1_0_1_0_1;
         ST_WR_HOLD:  strobes = 5'b1_0_1_1_1;
         ST_DONE:     strobes = 5'b0_1_1_1_0;
`ifdef SRAM_TURNAROUND_EN
         ST_TURN:     strobes = 5'b1_1_1_1_0;
`endif
         default:     strobes = 5'b0_1_1_1_0;
      endcase
   endfunction

   // Word offset and upper window bits alias; only the tag and word index matter.
   assign addr_unused_s = ^addr;
   assign hit_s         = (addr[31:WIN_BITS] == BASE_ADDR[31:WIN_BITS]);
   assign ack           = (rreq | wreq) & hit_s;
   assign acc_wr_s      = (state_r == ST_IDLE) & hit_s & wreq;
   assign acc_rd_s      = (state_r == ST_IDLE) & hit_s & rreq & ~wreq;
   assign rd_last_s     = (state_r == ST_RD) && (cnt_r == {CW{1'b0}});

   // Next-state and wait-counter logic; the counter reloads on entry to a timed state.
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      case (state_r)
         ST_IDLE: begin
            if (acc_wr_s) begin
`ifdef SRAM_TURNAROUND_EN
               state_nxt_s = last_rd_r ? ST_TURN : ST_WR_SETUP;
`else
               state_nxt_s = ST_WR_SETUP;
`endif
            end else if (acc_rd_s) begin
               state_nxt_s = ST_RD;
               cnt_nxt_s   = CW'(RD_WAIT - 1);
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_RD: begin
            if (cnt_r == {CW{1'b0}}) begin
               state_nxt_s = ST_DONE;
            end else begin
               cnt_nxt_s = cnt_r - CW'(1);
            end
         end
`ifdef SRAM_TURNAROUND_EN
         ST_TURN: state_nxt_s = ST_WR_SETUP;
`endif
         ST_WR_SETUP: begin
            state_nxt_s = ST_WR_PULSE;
            cnt_nxt_s   = CW'(WR_WAIT - 1);
         end
         ST_WR_PULSE: begin
            if (cnt_r == {CW{1'b0}}) begin
               state_nxt_s = ST_WR_HOLD;
            end else begin
               cnt_nxt_s = cnt_r - CW'(1);
            end
         end
         ST_WR_HOLD: state_nxt_s = ST_DONE;
         ST_DONE: begin
            // Stay parked until the master drops its request so it cannot retrigger.
            if (!rreq && !wreq) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_DONE;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = {CW{1'b0}};
         end
      endcase
   end

   // State register with strobes registered from the next state, so pins change on the edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r    <= ST_IDLE;
         cnt_r      <= {CW{1'b0}};
         {busy, sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe} <= 5'b0_1_1_1_0;
         rdata      <= 32'h0;
         sram_addr  <= {SRAM_AW{1'b0}};
         sram_dq_o  <= 32'h0;
`ifdef SRAM_TURNAROUND_EN
         last_rd_r  <= 1'b0;
`endif
      end else begin
         state_r <= state_nxt_s;
         cnt_r   <= cnt_nxt_s;
         {busy, sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe} <= strobes(state_nxt_s);
         if (acc_wr_s | acc_rd_s) begin
            sram_addr <= addr[SRAM_AW+1:2];
         end
         if (acc_wr_s) begin
            sram_dq_o <= wdata;
         end
         if (rd_last_s) begin
            rdata <= sram_dq_i;
         end
`ifdef SRAM_TURNAROUND_EN
         if (acc_wr_s) begin
            last_rd_r <= 1'b0;
         end else if (acc_rd_s) begin
            last_rd_r <= 1'b1;
         end
`endif
      end
   end

endmodule

// File: tb/tb_sram_bus_slave.sv
// Randomized bench for sram_bus_slave: a transaction-timeline model predicts every pin each cycle,
// with an SRAM device model behind the DUT and directed literal checks for the key scenarios.
module tb_sram_bus_slave;

   localparam int RD_WAIT = 2;
   localparam int WR_WAIT = 2;
`ifdef SRAM_TURNAROUND_EN
   localparam int TURN_EN = 1;
`else
   localparam int TURN_EN = 0;
`endif

   logic        clk;
   logic        reset;
   logic        rreq;
   logic        wreq;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        ack;
   logic        busy;
   logic [12:0] sram_addr;
   logic [31:0] sram_dq_o;
   logic [31:0] sram_dq_i;
   logic        sram_dq_oe;
   logic        sram_ce_n;
   logic        sram_oe_n;
   logic        sram_we_n;

   sram_bus_slave #(
      .BASE_ADDR(32'h0), .WIN_BITS(15), .SRAM_AW(13), .RD_WAIT(RD_WAIT), .WR_WAIT(WR_WAIT)
   ) dut (
      .clk(clk), .reset(reset), .rreq(rreq), .wreq(wreq), .addr(addr), .wdata(wdata),
      .rdata(rdata), .ack(ack), .busy(busy), .sram_addr(sram_addr), .sram_dq_o(sram_dq_o),
      .sram_dq_i(sram_dq_i), .sram_dq_oe(sram_dq_oe), .sram_ce_n(sram_ce_n),
      .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] seed(input int i);
      return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   // SRAM device: async read while selected, write on every edge with we_n low.
   logic [31:0] dev_mem [0:8191];
   logic        mem_init;
   assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? dev_mem[sram_addr] : 32'hA5A5_5A5A;
   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 8192; i++) dev_mem[i] <= seed(i);
      end else if (!sram_ce_n && !sram_we_n && sram_dq_oe) begin
         dev_mem[sram_addr] <= sram_dq_o;
      end
   end

   // Reference model: mode 0 idle, 1 read, 2 write, 3 done; k = cycles elapsed in the access.
   logic [31:0] ref_mem [0:8191];
   int          m_mode, m_k, m_len, m_turn;
   logic [12:0] m_addr;
   logic [31:0] m_wdata, m_rdata, m_pend;
   logic        m_last_rd;

   int n_vec, n_err;
   int obs_busy, obs_we, obs_oe, obs_ce, obs_turn;
   logic [31:0] obs_we_data;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic hit(input logic [31:0] a);
      return a[31:15] == 17'h0;
   endfunction

   task automatic model_reset();
      m_mode = 0; m_k = 0; m_len = 0; m_turn = 0;
      m_addr = 13'h0; m_wdata = 32'h0; m_rdata = 32'h0; m_pend = 32'h0; m_last_rd = 1'b0;
   endtask

   task automatic clear_obs();
      obs_busy = 0; obs_we = 0; obs_oe = 0; obs_ce = 0; obs_turn = 0; obs_we_data = 32'h0;
   endtask

   // Compare every DUT output with the model's timeline for the current cycle.
   task automatic compare();
      logic e_busy, e_ce, e_oe, e_we, e_dqoe;
      int j;
      e_busy = 1'b0; e_ce = 1'b1; e_oe = 1'b1; e_we = 1'b1; e_dqoe = 1'b0;
      if (m_mode == 1) begin
         e_busy = 1'b1; e_ce = 1'b0; e_oe = 1'b0;
      end else if (m_mode == 2) begin
         e_busy = 1'b1;
         if (m_k >= m_turn) begin
            j = m_k - m_turn;
            e_ce = 1'b0; e_dqoe = 1'b1;
            e_we = (j >= 1 && j <= WR_WAIT) ? 1'b0 : 1'b1;
         end
      end
      chk("busy", 32'(busy), 32'(e_busy));
      chk("ce_n", 32'(sram_ce_n), 32'(e_ce));
      chk("oe_n", 32'(sram_oe_n), 32'(e_oe));
      chk("we_n", 32'(sram_we_n), 32'(e_we));
      chk("dq_oe", 32'(sram_dq_oe), 32'(e_dqoe));
      chk("sram_addr", 32'(sram_addr), 32'(m_addr));
      chk("dq_o", sram_dq_o, m_wdata);
      chk("rdata", rdata, m_rdata);
      if (busy) obs_busy++;
      if (!sram_we_n && sram_dq_oe) begin obs_we++; obs_we_data = sram_dq_o; end
      if (!sram_oe_n) obs_oe++;
      if (!sram_ce_n) obs_ce++;
      if (busy && sram_ce_n && !sram_dq_oe) obs_turn++;
   endtask

   task automatic model_advance(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
      case (m_mode)
         0: begin
            if (hit(a) && w) begin
               m_mode = 2; m_k = 0;
               m_turn = (TURN_EN == 1 && m_last_rd) ? 1 : 0;
               m_len = WR_WAIT + 2 + m_turn;
               m_addr = a[14:2]; m_wdata = d; ref_mem[a[14:2]] = d; m_last_rd = 1'b0;
            end else if (hit(a) && r) begin
               m_mode = 1; m_k = 0; m_len = RD_WAIT;
               m_addr = a[14:2]; m_pend = ref_mem[a[14:2]]; m_last_rd = 1'b1;
            end
         end
         1, 2: begin
            m_k++;
            if (m_k == m_len) begin
               if (m_mode == 1) m_rdata = m_pend;
               m_mode = 3;
            end
         end
         default: if (!r && !w) m_mode = 0;
      endcase
   endtask

   // One bus cycle: check outputs, drive inputs, check ack, advance the model.
   task automatic step(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
      compare();
      rreq = r; wreq = w; addr = a; wdata = d;
      #1;
      chk("ack", 32'(ack), 32'((r | w) & hit(a)));
      model_advance(r, w, a, d);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   function automatic logic [31:0] rand_addr();
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(0, 9) < 2) begin
         a[15] = 1'b1;
      end else begin
         a[31:15] = 17'h0;
         a[14:2] = ($urandom_range(0, 1) == 1) ? 13'($urandom_range(0, 7))
                                               : 13'h1FF8 + 13'($urandom_range(0, 7));
      end
      return a;
   endfunction

   initial begin
      n_vec = 0; n_err = 0;
      reset = 1'b0; rreq = 1'b0; wreq = 1'b0; addr = 32'h0; wdata = 32'h0;
      mem_init = 1'b1;
      for (int i = 0; i < 8192; i++) ref_mem[i] = seed(i);
      model_reset();
      clear_obs();
      repeat (2) @(negedge clk);
      mem_init = 1'b0;

      // Reset values while idle.
      chk("t1_rdata", rdata, 32'h0);
      chk("t1_busy", 32'(busy), 32'h0);
      chk("t1_strobes", 32'({sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}), 32'hE);
      chk("t1_sram_addr", 32'(sram_addr), 32'h0);
      compare();
      reset = 1'b1;
      idle(2);

      // Read of 0x10 returning 0xDEADBEEF, with the request held past completion.
      step(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF);
      idle(6);
      clear_obs();
      step(1'b1, 1'b0, 32'h10, 32'h0);
      chk("t2_sram_addr", 32'(sram_addr), 32'h4);
      chk("t2_busy", 32'(busy), 32'h1);
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'h10, 32'h0);
      chk("t2_rdata", rdata, 32'hDEAD_BEEF);
      chk("t2_busy_cycles", 32'(obs_busy), 32'(RD_WAIT));
      idle(2);

      // Write at the top of the window, following a read.
      clear_obs();
      step(1'b0, 1'b1, 32'h7FFC, 32'h1234_5678);
      chk("t3_sram_addr", 32'(sram_addr), 32'h1FFF);
      idle(7);
      chk("t3_we_cycles", 32'(obs_we), 32'h2);
      chk("t3_we_data", obs_we_data, 32'h1234_5678);
      chk("t3_busy_cycles", 32'(obs_busy), 32'(4 + TURN_EN));
      chk("t6_turn_after_read", 32'(obs_turn), 32'(TURN_EN));

      // Out-of-window request is ignored.
      clear_obs();
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h8010, 32'h0);
      chk("t4_ack", 32'(ack), 32'h0);
      chk("t4_busy_cycles", 32'(obs_busy), 32'h0);
      chk("t4_ce_cycles", 32'(obs_ce), 32'h0);
      idle(2);

      // Simultaneous read and write: write wins, rdata untouched, no turnaround after a write.
      clear_obs();
      step(1'b1, 1'b1, 32'h20, 32'hCAFE_F00D);
      idle(7);
      chk("t5_we_cycles", 32'(obs_we), 32'h2);
      chk("t5_oe_cycles", 32'(obs_oe), 32'h0);
      chk("t5_rdata", rdata, 32'hDEAD_BEEF);
      chk("t6_turn_after_write", 32'(obs_turn), 32'h0);

      // Reset asserted during the write pulse drops the strobes at once.
      step(1'b0, 1'b1, 32'h24, 32'h0BAD_F00D);
      step(1'b0, 1'b0, 32'h0, 32'h0);
      step(1'b0, 1'b0, 32'h0, 32'h0);
      chk("t5_in_pulse", 32'(sram_we_n), 32'h0);
      reset = 1'b0;
      #1;
      chk("t5_rst_we_n", 32'(sram_we_n), 32'h1);
      chk("t5_rst_dq_oe", 32'(sram_dq_oe), 32'h0);
      chk("t5_rst_ce_n", 32'(sram_ce_n), 32'h1);
      chk("t5_rst_busy", 32'(busy), 32'h0);
      model_reset();
      @(negedge clk);
      compare();
      @(negedge clk);
      reset = 1'b1;
      idle(2);
      step(1'b1, 1'b0, 32'h24, 32'h0);
      idle(4);
      chk("t5_readback", rdata, 32'h0BAD_F00D);

      // Randomized traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         step(($urandom_range(0, 9) < 4) ? 1'b1 : 1'b0,
              ($urandom_range(0, 9) < 3) ? 1'b1 : 1'b0,
              rand_addr(), $urandom);
      end
      idle(8);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
